arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of every data port.
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in1, input, WIDTH bits: channel-1 data.
REQ-005 The block SHALL have port valid1, input, 1 bit: channel-1 data valid.
REQ-006 The block SHALL have port ready1, output, 1 bit: channel-1 beat accepted this cycle.
REQ-007 The block SHALL have port in2, input, WIDTH bits: channel-2 data.
REQ-008 The block SHALL have port valid2, input, 1 bit: channel-2 data valid.
REQ-009 The block SHALL have port ready2, output, 1 bit: channel-2 beat accepted this cycle.
REQ-010 The block SHALL have port out, output, WIDTH bits: merged data, registered.
REQ-011 The block SHALL have port sel, output, 1 bit: source tag of out (0 = in1, 1 = in2), registered, same encoding as the DEMUX sel input.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out/sel hold a beat.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat this cycle.

Function
REQ-014 A beat SHALL transfer on an input channel at a rising clk edge when validN=1 and readyN=1, and on the output when out_valid=1 and out_ready=1.
REQ-015 Internal signal load_en SHALL be defined as (out_valid=0) OR (out_ready=1).
REQ-016 State last SHALL record the channel of the most recent accepted input beat, 0 = in1, 1 = in2.
REQ-017 grant1 SHALL be valid1 AND (valid2=0 OR last=1); grant2 SHALL be valid2 AND (valid1=0 OR last=0); at most one grant SHALL be high.
REQ-018 ready1 SHALL equal load_en AND grant1, and ready2 SHALL equal load_en AND grant2, both combinational, with no combinational path from out_ready to out, sel or out_valid.
REQ-019 On an edge with readyN=1, the block SHALL load out with inN, set sel to N-1, set out_valid to 1 and set last to N-1.
REQ-020 On an edge with load_en=1 and neither ready high, the block SHALL set out_valid to 0 and hold out, sel and last.
REQ-021 On an edge with load_en=0 (stall), the block SHALL hold out, sel, out_valid and last unchanged.
REQ-022 Latency from input transfer to out_valid SHALL be exactly 1 cycle, and throughput SHALL be 1 beat per cycle with no bubbles when out_ready=1.
REQ-023 Fairness: with both channels continuously valid and no stall, accepted sel SHALL strictly alternate 0,1,0,1,...; a channel SHALL wait at most 1 beat.
REQ-024 A simultaneous output drain and input accept on one edge SHALL replace the beat with no loss and no duplication.
REQ-025 Input data SHALL be sampled only on transfer edges; changes of inN while readyN=0 SHALL have no effect.

Reset
REQ-026 While rst=1, the block SHALL asynchronously (without waiting for clk) force out=0, sel=0, out_valid=0 and last=1, so that in1 wins the first contention.
REQ-027 While rst=1, ready1 and ready2 SHALL be 0, and no beat SHALL be accepted on the edge at which rst deasserts.
REQ-028 Reset mid-operation SHALL discard any held beat, and the first post-reset contention SHALL grant in1.

Verification
REQ-029 Scenario (single channel): valid1=1, in1=8'hA5, valid2=0, out_ready=1 -> ready1=1; next edge out=8'hA5, sel=0, out_valid=1, last=0.
REQ-030 Scenario (continuous contention): valid1=valid2=1 held with in1=8'h11, in2=8'h22, out_ready=1, after reset -> out sequence 11,22,11,22 and sel 0,1,0,1 on consecutive cycles.
REQ-031 Scenario (backpressure): out_valid=1, out_ready=0, both inputs valid -> ready1=ready2=0, out/sel stable for 3 cycles; out_ready=1 -> the pending grant loads next edge.
REQ-032 Scenario (fairness after a solo beat): only in2 valid for one beat (last=1), then both valid -> next accepted beat has sel=0.
REQ-033 Scenario (drain, no input): out_valid=1, out_ready=1, valid1=valid2=0 -> next edge out_valid=0 with out unchanged.
REQ-034 Scenario (asynchronous reset): pulse rst between clk edges while out_valid=1 -> out_valid=0, out=0, sel=0 immediately; then both valid -> first sel=0.

Source files
------------

// File: rtl/arb_mux.sv
// Two-input round-robin merge with a single registered output stage.
// Each output beat is tagged with its source channel on sel (0 = in1, 1 = in2).
module arb_mux #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic             valid1,
    output logic             ready1,
    input  logic [WIDTH-1:0] in2,
    input  logic             valid2,
    output logic             ready2,
    output logic [WIDTH-1:0] out,
    output logic             sel,
    output logic             out_valid,
    input  logic             out_ready
);

    logic last;
    logic load_en;
    logic grant1;
    logic grant2;

    // ready depends on out_ready only through load_en; the output registers never see it directly
    always_comb begin
        load_en = ~out_valid | out_ready;
        grant1  = valid1 & (~valid2 | last);
        grant2  = valid2 & (~valid1 | ~last);
        ready1  = load_en & grant1 & ~rst;
        ready2  = load_en & grant2 & ~rst;
    end

    // last resets to 1 so that in1 wins the first contention after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            sel       <= 1'b0;
            out_valid <= 1'b0;
            last      <= 1'b1;
        end else if (load_en) begin
            if (ready1) begin
                out       <= in1;
                sel       <= 1'b0;
                out_valid <= 1'b1;
                last      <= 1'b0;
            end else if (ready2) begin
                out       <= in2;
                sel       <= 1'b1;
                out_valid <= 1'b1;
                last      <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed and random checks of arb_mux against a cycle model plus a scoreboard of
// accepted beats that is drained as the output transfers.
module tb_arb_mux;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in1;
    logic             valid1;
    logic             ready1;
    logic [WIDTH-1:0] in2;
    logic             valid2;
    logic             ready2;
    logic [WIDTH-1:0] out;
    logic             sel;
    logic             out_valid;
    logic             out_ready;

    int tests;
    int fails;

    // bench-side model of the output stage
    logic             m_valid;
    logic [WIDTH-1:0] m_out;
    logic             m_sel;
    logic             m_last;
    logic [WIDTH:0]   sb[$];

    logic [WIDTH-1:0] seq_out[4];
    logic             seq_sel[4];
    logic [WIDTH-1:0] held_out;
    logic             held_sel;

    arb_mux #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .valid1    (valid1),
        .ready1    (ready1),
        .in2       (in2),
        .valid2    (valid2),
        .ready2    (ready2),
        .out       (out),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = '0;
        m_sel   = 1'b0;
        m_last  = 1'b1;
        sb.delete();
    endtask

    // One clock: check at negedge, advance the model at posedge, return at posedge+1.
    task automatic step();
        logic le, g1, g2, e1, e2;
        logic [WIDTH:0] beat;
        @(negedge clk);
        le = !m_valid || out_ready;
        g1 = valid1 && (!valid2 || m_last);
        g2 = valid2 && (!valid1 || !m_last);
        e1 = le && g1;
        e2 = le && g2;
        chk("ready1", 32'(ready1), 32'(e1));
        chk("ready2", 32'(ready2), 32'(e2));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out", 32'(out), 32'(m_out));
            chk("sel", 32'(sel), 32'(m_sel));
        end
        if (m_valid && out_ready) begin
            chk("sb_depth", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                beat = sb.pop_front();
                chk("sb_beat", 32'({sel, out}), 32'(beat));
            end
        end
        @(posedge clk);
        if (le) begin
            if (e1) begin
                m_out = in1; m_sel = 1'b0; m_valid = 1'b1; m_last = 1'b0;
                sb.push_back({1'b0, in1});
            end else if (e2) begin
                m_out = in2; m_sel = 1'b1; m_valid = 1'b1; m_last = 1'b1;
                sb.push_back({1'b1, in2});
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0; in1 = '0; in2 = '0; valid1 = 1'b0; valid2 = 1'b0; out_ready = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        valid1 = 1'b1; valid2 = 1'b1; out_ready = 1'b1;
        #1;
        chk("rst_ready1", 32'(ready1), 32'd0);
        chk("rst_ready2", 32'(ready2), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        valid1 = 1'b0; valid2 = 1'b0;

        // single channel
        valid1 = 1'b1; in1 = 8'hA5;
        step();
        chk("single_out", 32'(out), 32'hA5);
        chk("single_sel", 32'(sel), 32'd0);
        chk("single_valid", 32'(out_valid), 32'd1);

        // drain with no input: valid drops, data held
        valid1 = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_out", 32'(out), 32'hA5);

        // solo beat on in2, then contention goes to in1
        valid2 = 1'b1; in2 = 8'h3C;
        step();
        chk("solo2_sel", 32'(sel), 32'd1);
        valid1 = 1'b1; in1 = 8'h44; in2 = 8'h55;
        step();
        chk("fair_out", 32'(out), 32'h44);
        chk("fair_sel", 32'(sel), 32'd0);

        // backpressure with both inputs valid; input data wiggles with no effect
        out_ready = 1'b0;
        held_out = out;
        held_sel = sel;
        for (int i = 0; i < 3; i++) begin
            in1 = 8'h60 + 8'(i);
            step();
            chk("bp_ready1", 32'(ready1), 32'd0);
            chk("bp_ready2", 32'(ready2), 32'd0);
            chk("bp_out", 32'(out), 32'(held_out));
            chk("bp_sel", 32'(sel), 32'(held_sel));
        end
        in2 = 8'h77;
        out_ready = 1'b1;
        step();
        chk("bp_release_out", 32'(out), 32'h77);
        chk("bp_release_sel", 32'(sel), 32'd1);

        // asynchronous reset between edges while a beat is held
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_sel", 32'(sel), 32'd0);
        rst = 1'b0;
        model_reset();

        // continuous contention with no stall
        in1 = 8'h11; in2 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            step();
            seq_out[i] = out;
            seq_sel[i] = sel;
        end
        chk("cont_out0", 32'(seq_out[0]), 32'h11);
        chk("cont_out1", 32'(seq_out[1]), 32'h22);
        chk("cont_out2", 32'(seq_out[2]), 32'h11);
        chk("cont_out3", 32'(seq_out[3]), 32'h22);
        chk("cont_sel0", 32'(seq_sel[0]), 32'd0);
        chk("cont_sel1", 32'(seq_sel[1]), 32'd1);
        chk("cont_sel2", 32'(seq_sel[2]), 32'd0);
        chk("cont_sel3", 32'(seq_sel[3]), 32'd1);

        // random traffic against the model and scoreboard
        for (int i = 0; i < 80; i++) begin
            valid1    = 1'($urandom_range(0, 1));
            valid2    = 1'($urandom_range(0, 1));
            in1       = 8'($urandom);
            in2       = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        chk("sb_final_depth", 32'(sb.size()), 32'(m_valid));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
